fp_ieee754_pack: RTL and testbench

//  Encoder side of the IEEE754(NX, NM) packed float format: converts an unpacked

---
 rtl/fp_ieee754_pack.sv | 150 +++++++++++++++
 tb/tb_fp_ieee754_pack.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_ieee754_pack.sv
// Packs an unpacked float (sign, unbiased exponent, mantissa with guard/sticky) into
// IEEE754 {sign, exp, frac}: iterative normalisation, round-to-nearest-even, subnormals
// and specials. Optional FP_PACK_FLAGS_EN adds OUT_FLAGS = {overflow, underflow, inexact}.
module fp_ieee754_pack #(
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 IN_SIGN,
  input  logic signed [NX+1:0] IN_EXP,
  input  logic [NM+3:0]        IN_MANT,
  input  logic                 IN_ZERO,
  input  logic                 IN_INF,
  input  logic                 IN_NAN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [NX+NM:0]       OUT_VALUE
`ifdef FP_PACK_FLAGS_EN
  ,
  output logic [2:0]           OUT_FLAGS
`endif
);

  localparam int EW   = NX + 2;
  localparam int MW   = NM + 4;
  localparam int BIAS = (1 << (NX - 1)) - 1;
  localparam logic signed [EW-1:0] EMIN     = EW'(1 - BIAS);
  localparam logic signed [EW:0]   EXP_MAXB = (EW+1)'((1 << NX) - 1);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic [NX+NM:0]        val_q, val_d;
`ifdef FP_PACK_FLAGS_EN
  logic [2:0]            flg_q, flg_d;
  logic                  inexact;
`endif

  // Rounding datapath, evaluated from the normalised register contents.
  logic                  rnd_up, rnd_carry;
  logic [NM+1:0]         mant_r;
  logic [NM:0]           mant_s;
  logic signed [EW:0]    exp_b;
  logic                  ovf;

  assign rnd_up    = mant_q[1] & (mant_q[0] | mant_q[2]);
  assign mant_r    = mant_q[MW-1:2] + {{(NM+1){1'b0}}, rnd_up};
  assign rnd_carry = mant_r[NM+1];
  assign mant_s    = rnd_carry ? mant_r[NM+1:1] : mant_r[NM:0];
  assign exp_b     = $signed({exp_q[EW-1], exp_q}) + $signed((EW+1)'(BIAS))
                   + $signed({{EW{1'b0}}, rnd_carry});
  assign ovf       = exp_b >= EXP_MAXB;
`ifdef FP_PACK_FLAGS_EN
  assign inexact   = mant_q[1] | mant_q[0];
  assign OUT_FLAGS = flg_q;
`endif

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign OUT_VALUE = val_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    val_d   = val_q;
`ifdef FP_PACK_FLAGS_EN
    flg_d   = flg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          sign_d  = IN_SIGN;
          exp_d   = IN_EXP;
          mant_d  = IN_MANT;
          state_d = S_DONE;
`ifdef FP_PACK_FLAGS_EN
          flg_d   = '0;
`endif
          if (IN_NAN)
            val_d = {IN_SIGN, {NX{1'b1}}, 1'b1, {(NM-1){1'b0}}};
          else if (IN_INF)
            val_d = {IN_SIGN, {NX{1'b1}}, {NM{1'b0}}};
          else if (IN_ZERO || IN_MANT == '0)
            val_d = {IN_SIGN, {(NX+NM){1'b0}}};
          else
            state_d = S_NORM;
        end
      end
      S_NORM: begin
        // Right shifts fold both guard and sticky into the new sticky bit.
        if (mant_q[MW-1] || (exp_q < EMIN && mant_q != '0)) begin
          mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + 1'b1;
        end else if (!mant_q[MW-2] && mant_q != '0 && exp_q > EMIN) begin
          mant_d = {mant_q[MW-2:0], 1'b0};
          exp_d  = exp_q - 1'b1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (ovf)
          val_d = {sign_q, {NX{1'b1}}, {NM{1'b0}}};
        else if (mant_s[NM])
          val_d = {sign_q, exp_b[NX-1:0], mant_s[NM-1:0]};
        else
          val_d = {sign_q, {NX{1'b0}}, mant_s[NM-1:0]};
`ifdef FP_PACK_FLAGS_EN
        flg_d = {ovf, inexact & ~ovf & ~mant_s[NM], inexact | ovf};
`endif
      end
      S_DONE: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      val_q   <= '0;
`ifdef FP_PACK_FLAGS_EN
      flg_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      val_q   <= val_d;
`ifdef FP_PACK_FLAGS_EN
      flg_q   <= flg_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_ieee754_pack.sv
// Directed bench for fp_ieee754_pack (NX=8, NM=23): normalisation, rounding, specials,
// subnormals, backpressure and mid-operation reset. Flags checked when FP_PACK_FLAGS_EN is set.
module tb_fp_ieee754_pack;

  localparam logic [26:0] CAR   = 27'h4000000;
  localparam logic [26:0] HID   = 27'h2000000;
  localparam logic [26:0] FRAC1 = 27'h1FFFFFC;
  localparam logic [26:0] LSB   = 27'h0000004;
  localparam logic [26:0] GRD   = 27'h0000002;
  localparam logic [26:0] STK   = 27'h0000001;

  logic              CLK, RST;
  logic              IN_VALID, IN_READY, IN_SIGN, IN_ZERO, IN_INF, IN_NAN;
  logic signed [9:0] IN_EXP;
  logic [26:0]       IN_MANT;
  logic              OUT_VALID, OUT_READY;
  logic [31:0]       OUT_VALUE;
`ifdef FP_PACK_FLAGS_EN
  logic [2:0]        OUT_FLAGS;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string             name;
    logic              s;
    logic signed [9:0] e;
    logic [26:0]       m;
    logic              nan, inf, zero;
    logic [31:0]       val;
    logic [2:0]        flg;
    int                lat;
    logic              exact;
  } vec_t;

  fp_ieee754_pack #(.NX(8), .NM(23)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SIGN(IN_SIGN),
    .IN_EXP(IN_EXP), .IN_MANT(IN_MANT),
    .IN_ZERO(IN_ZERO), .IN_INF(IN_INF), .IN_NAN(IN_NAN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_VALUE(OUT_VALUE)
`ifdef FP_PACK_FLAGS_EN
    , .OUT_FLAGS(OUT_FLAGS)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Waits for IN_READY, presents one word, and returns the number of rising edges
  // after the accept edge at which OUT_VALID is first seen (-1 on timeout).
  task automatic send(input logic s, input logic signed [9:0] e, input logic [26:0] m,
                      input logic nan, input logic inf, input logic zero, output int lat);
    int n = 0;
    while (IN_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait got %b expected 1", IN_READY);
    end
    IN_VALID = 1'b1; IN_SIGN = s; IN_EXP = e; IN_MANT = m;
    IN_NAN = nan; IN_INF = inf; IN_ZERO = zero;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0; IN_NAN = 1'b0; IN_INF = 1'b0; IN_ZERO = 1'b0;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (OUT_VALID === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic pop();
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", IN_READY); end
    checks++;
    if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", OUT_VALID); end
    checks++;
    if (OUT_VALUE !== 32'h0) begin errors++; $display("FAIL reset_out_value got %h expected 00000000", OUT_VALUE); end
`ifdef FP_PACK_FLAGS_EN
    checks++;
    if (OUT_FLAGS !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", OUT_FLAGS); end
`endif
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_normalise();
    vec_t t[4];
    int   lat;
    t = '{'{"one",      1'b0,  10'sd0, HID,       1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000, 2,  1'b1},
          '{"carry_in", 1'b0,  10'sd0, CAR,       1'b0, 1'b0, 1'b0, 32'h40000000, 3'b000, 3,  1'b1},
          '{"left20",   1'b0, 10'sd20, 27'h20,    1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000, 22, 1'b1},
          '{"neg_1p5",  1'b1,  10'sd0, HID | 27'h1000000, 1'b0, 1'b0, 1'b0, 32'hBFC00000, 3'b000, 2, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      send(t[i].s, t[i].e, t[i].m, t[i].nan, t[i].inf, t[i].zero, lat);
      checks++;
      if (OUT_VALUE !== t[i].val) begin errors++; $display("FAIL %s value got %h expected %h", t[i].name, OUT_VALUE, t[i].val); end
      checks++;
      if (lat != t[i].lat) begin errors++; $display("FAIL %s latency got %0d expected %0d", t[i].name, lat, t[i].lat); end
`ifdef FP_PACK_FLAGS_EN
      checks++;
      if (OUT_FLAGS !== t[i].flg) begin errors++; $display("FAIL %s flags got %b expected %b", t[i].name, OUT_FLAGS, t[i].flg); end
`endif
      pop();
    end
  endtask

  task automatic test_round();
    vec_t t[5];
    int   lat;
    t = '{'{"tie_even_carry", 1'b0,   10'sd0, HID | FRAC1 | GRD,       1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001, 2, 1'b1},
          '{"tie_even_down",  1'b0,   10'sd0, HID | GRD,               1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b001, 2, 1'b1},
          '{"above_half",     1'b0,   10'sd0, HID | GRD | STK,         1'b0, 1'b0, 1'b0, 32'h3F800001, 3'b001, 2, 1'b1},
          '{"tie_odd_up",     1'b0,   10'sd0, HID | LSB | GRD,         1'b0, 1'b0, 1'b0, 32'h3F800002, 3'b001, 2, 1'b1},
          '{"round_to_inf",   1'b0, 10'sd127, HID | FRAC1 | GRD | STK, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101, 2, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      send(t[i].s, t[i].e, t[i].m, t[i].nan, t[i].inf, t[i].zero, lat);
      checks++;
      if (OUT_VALUE !== t[i].val) begin errors++; $display("FAIL %s value got %h expected %h", t[i].name, OUT_VALUE, t[i].val); end
      checks++;
      if (lat != t[i].lat) begin errors++; $display("FAIL %s latency got %0d expected %0d", t[i].name, lat, t[i].lat); end
`ifdef FP_PACK_FLAGS_EN
      checks++;
      if (OUT_FLAGS !== t[i].flg) begin errors++; $display("FAIL %s flags got %b expected %b", t[i].name, OUT_FLAGS, t[i].flg); end
`endif
      pop();
    end
  endtask

  task automatic test_specials();
    vec_t t[7];
    int   lat;
    t = '{'{"overflow",     1'b0, 10'sd128, HID,  1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101, 2, 1'b1},
          '{"max_exp",      1'b0, 10'sd127, HID,  1'b0, 1'b0, 1'b0, 32'h7F000000, 3'b000, 2, 1'b1},
          '{"nan_neg",      1'b1,   10'sd0, HID,  1'b1, 1'b0, 1'b0, 32'hFFC00000, 3'b000, 1, 1'b0},
          '{"nan_over_inf", 1'b0,   10'sd0, 27'h0, 1'b1, 1'b1, 1'b1, 32'h7FC00000, 3'b000, 1, 1'b0},
          '{"inf_neg",      1'b1,   10'sd3, HID,  1'b0, 1'b1, 1'b1, 32'hFF800000, 3'b000, 1, 1'b0},
          '{"zero_neg",     1'b1,   10'sd0, HID,  1'b0, 1'b0, 1'b1, 32'h80000000, 3'b000, 1, 1'b0},
          '{"mant_zero",    1'b0,   10'sd5, 27'h0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000, 1, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      send(t[i].s, t[i].e, t[i].m, t[i].nan, t[i].inf, t[i].zero, lat);
      checks++;
      if (OUT_VALUE !== t[i].val) begin errors++; $display("FAIL %s value got %h expected %h", t[i].name, OUT_VALUE, t[i].val); end
      checks++;
      if (t[i].exact ? (lat != t[i].lat) : (lat < 0 || lat > t[i].lat)) begin
        errors++;
        $display("FAIL %s latency got %0d expected %0d", t[i].name, lat, t[i].lat);
      end
`ifdef FP_PACK_FLAGS_EN
      checks++;
      if (OUT_FLAGS !== t[i].flg) begin errors++; $display("FAIL %s flags got %b expected %b", t[i].name, OUT_FLAGS, t[i].flg); end
`endif
      pop();
    end
  endtask

  task automatic test_subnormal();
    vec_t t[4];
    int   lat;
    t = '{'{"sub_half",      1'b0, -10'sd127, HID,                1'b0, 1'b0, 1'b0, 32'h00400000, 3'b000, 3,  1'b1},
          '{"sub_min",       1'b0, -10'sd149, HID,                1'b0, 1'b0, 1'b0, 32'h00000001, 3'b000, 25, 1'b1},
          '{"sub_tie_zero",  1'b0, -10'sd150, HID,                1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011, 26, 1'b1},
          '{"sub_to_normal", 1'b0, -10'sd127, HID | FRAC1 | GRD,  1'b0, 1'b0, 1'b0, 32'h00800000, 3'b001, 3,  1'b1}};
    for (int i = 0; i < 4; i++) begin
      send(t[i].s, t[i].e, t[i].m, t[i].nan, t[i].inf, t[i].zero, lat);
      checks++;
      if (OUT_VALUE !== t[i].val) begin errors++; $display("FAIL %s value got %h expected %h", t[i].name, OUT_VALUE, t[i].val); end
      checks++;
      if (lat != t[i].lat) begin errors++; $display("FAIL %s latency got %0d expected %0d", t[i].name, lat, t[i].lat); end
`ifdef FP_PACK_FLAGS_EN
      checks++;
      if (OUT_FLAGS !== t[i].flg) begin errors++; $display("FAIL %s flags got %b expected %b", t[i].name, OUT_FLAGS, t[i].flg); end
`endif
      pop();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(1'b0, 10'sd0, HID, 1'b0, 1'b0, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALUE !== 32'h3F800000 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got value %h valid %b ready %b expected 3f800000 1 0",
                 c, OUT_VALUE, OUT_VALID, IN_READY);
      end
    end
    pop();
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL after_pop got ready %b valid %b expected 1 0", IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    IN_VALID = 1'b1; IN_SIGN = 1'b0; IN_EXP = 10'sd20; IN_MANT = 27'h20;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || OUT_VALUE !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got valid %b ready %b value %h expected 0 1 00000000",
               OUT_VALID, IN_READY, OUT_VALUE);
    end
    RST = 1'b0;
    @(negedge CLK);
    send(1'b1, 10'sd0, HID | 27'h1000000, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if (OUT_VALUE !== 32'hBFC00000) begin errors++; $display("FAIL post_reset value got %h expected bfc00000", OUT_VALUE); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL post_reset latency got %0d expected 2", lat); end
    pop();
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_SIGN = 1'b0; IN_EXP = '0; IN_MANT = '0;
    IN_ZERO = 1'b0; IN_INF = 1'b0; IN_NAN = 1'b0; OUT_READY = 1'b0;
    test_reset();
    test_normalise();
    test_round();
    test_specials();
    test_subnormal();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
